// File: rtl/dram_pkg.sv
// Shared encodings for the data-RAM arbiter: access sizes, read-owner tags, CPU legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DBG  = 2'b10
    } own_e;

    function automatic logic size_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dram_ld_align.sv
// Load-data lane select plus zero/sign extension for byte, half and word loads.
// Latency: combinational.
// Backpressure: none.
module dram_ld_align
    import dram_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sgn & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dram_arbiter.sv
// Single-port-per-direction data-RAM arbiter: MA stage has priority, debug port forced through after STARVE_MAX waits.
// Latency: writes at grant edge; load data and rvalid appear the cycle after the read grant.
// Backpressure: cpu_stall when debug wins; debug request held until dbg_ack.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int DRWIDTH    = 11,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [DRWIDTH+1:0] cpu_adr,
    input  logic [1:0]         cpu_size,
    input  logic               cpu_signed,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_stall,
    output logic               cpu_misalign,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_rvalid,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [DRWIDTH-1:0] dbg_adr,
    input  logic [31:0]        dbg_wdata,
    output logic               dbg_ack,
    output logic [31:0]        dbg_rdata,
    output logic               dbg_rvalid,
    output logic [DRWIDTH-1:0] ram_radr,
    input  logic [31:0]        ram_rdata,
    output logic [DRWIDTH-1:0] ram_wadr,
    output logic [31:0]        ram_wdata,
    output logic [3:0]         ram_wen
);

    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0]     starve_cnt;
    own_e               rd_owner;
    logic [1:0]         rd_off;
    logic [1:0]         rd_size;
    logic               rd_signed;
    logic [31:0]        cpu_rdata_q;
    logic [31:0]        dbg_rdata_q;
    logic [31:0]        ld_data;

    logic               dbg_win;
    logic               cpu_win;
    logic               cpu_legal;
    logic               cpu_acc;
    logic [DRWIDTH-1:0] cpu_word;

    assign cpu_word  = cpu_adr[DRWIDTH+1:2];
    assign cpu_legal = size_legal(cpu_size, cpu_adr[1:0]);

    // All grants are gated by rst_n so nothing reaches the RAM while in reset.
    assign dbg_win   = rst_n & dbg_req & (~cpu_req | (starve_cnt == SCW'(STARVE_MAX)));
    assign cpu_win   = rst_n & cpu_req & ~dbg_win;
    assign cpu_acc   = cpu_win & cpu_legal;
    assign cpu_stall = rst_n & cpu_req & dbg_win;
    assign dbg_ack   = dbg_win;

    always_comb begin
        ram_wen  = 4'b0000;
        ram_wadr = cpu_word;
        ram_radr = cpu_word;
        case (cpu_size)
            SZ_BYTE: ram_wdata = {4{cpu_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{cpu_wdata[15:0]}};
            default: ram_wdata = cpu_wdata;
        endcase
        if (dbg_win) begin
            ram_wadr  = dbg_adr;
            ram_radr  = dbg_adr;
            ram_wdata = dbg_wdata;
            if (dbg_we) ram_wen = 4'b1111;
        end else if (cpu_acc && cpu_we) begin
            case (cpu_size)
                SZ_BYTE: ram_wen = 4'b0001 << cpu_adr[1:0];
                SZ_HALF: ram_wen = cpu_adr[1] ? 4'b1100 : 4'b0011;
                default: ram_wen = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt   <= '0;
            rd_owner     <= OWN_NONE;
            rd_off       <= 2'b00;
            rd_size      <= SZ_WORD;
            rd_signed    <= 1'b0;
            cpu_misalign <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (dbg_ack || !dbg_req)
                starve_cnt <= '0;
            else if (starve_cnt != SCW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            cpu_misalign <= cpu_win & ~cpu_legal;

            if (dbg_win && !dbg_we) begin
                rd_owner <= OWN_DBG;
            end else if (cpu_acc && !cpu_we) begin
                rd_owner  <= OWN_CPU;
                rd_off    <= cpu_adr[1:0];
                rd_size   <= cpu_size;
                rd_signed <= cpu_signed;
            end else begin
                rd_owner <= OWN_NONE;
            end

            if (cpu_rvalid) cpu_rdata_q <= ld_data;
            if (dbg_rvalid) dbg_rdata_q <= ram_rdata;
        end
    end

    dram_ld_align u_align (
        .rdata  (ram_rdata),
        .offset (rd_off),
        .size   (rd_size),
        .sgn    (rd_signed),
        .data   (ld_data)
    );

    // Reset in the return cycle drops the in-flight read.
    assign cpu_rvalid = rst_n & (rd_owner == OWN_CPU);
    assign dbg_rvalid = rst_n & (rd_owner == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? ld_data   : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? ram_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural byte-enabled 1r1w RAM.
module tb_dram_arbiter;

    localparam int DRW = 11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cpu_req, cpu_we, cpu_signed;
    logic [DRW+1:0] cpu_adr;
    logic [1:0]     cpu_size;
    logic [31:0]    cpu_wdata;
    logic           cpu_stall, cpu_misalign, cpu_rvalid;
    logic [31:0]    cpu_rdata;
    logic           dbg_req, dbg_we;
    logic [DRW-1:0] dbg_adr;
    logic [31:0]    dbg_wdata;
    logic           dbg_ack, dbg_rvalid;
    logic [31:0]    dbg_rdata;
    logic [DRW-1:0] ram_radr, ram_wadr;
    logic [31:0]    ram_rdata, ram_wdata;
    logic [3:0]     ram_wen;

    logic [31:0] mem [0:(1<<DRW)-1];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_wadr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_radr];
    end

    dram_arbiter #(.DRWIDTH(DRW), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_misalign(cpu_misalign), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .ram_radr(ram_radr), .ram_rdata(ram_rdata), .ram_wadr(ram_wadr),
        .ram_wdata(ram_wdata), .ram_wen(ram_wen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [DRW+1:0] adr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_size = size;
        cpu_signed = sgn; cpu_wdata = wd;
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_op(1'b1, 13'h004, 2'b10, 1'b0, 32'hDEAD_BEEF);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 11'd3; dbg_wdata = 32'h1;
        #1;
        tests++; if (ram_wen !== 4'b0000) begin fails++; $display("FAIL rst_wen got %b exp 0000", ram_wen); end
        tests++; if (dbg_ack !== 1'b0) begin fails++; $display("FAIL rst_dbg_ack got %b exp 0", dbg_ack); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
        tick(); tick();
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if ({cpu_misalign, cpu_rvalid, dbg_rvalid} !== 3'b000) begin
            fails++; $display("FAIL rst_regs got %b exp 000", {cpu_misalign, cpu_rvalid, dbg_rvalid}); end
    endtask

    task automatic test_byte();
        cpu_op(1'b1, 13'h006, 2'b00, 1'b0, 32'h0000_00A5);
        tests++; if (ram_wen !== 4'b0100) begin fails++; $display("FAIL byte_wen got %b exp 0100", ram_wen); end
        tests++; if (ram_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL byte_wdata got %h exp a5a5a5a5", ram_wdata); end
        tests++; if (ram_wadr !== 11'd1) begin fails++; $display("FAIL byte_wadr got %0d exp 1", ram_wadr); end
        tick();
        cpu_op(1'b0, 13'h006, 2'b00, 1'b1, 32'h0);
        tests++; if (ram_wen !== 4'b0000) begin fails++; $display("FAIL byte_ld_wen got %b exp 0000", ram_wen); end
        tick();
        idle();
        tests++; if (cpu_rvalid !== 1'b1) begin fails++; $display("FAIL byte_rvalid got %b exp 1", cpu_rvalid); end
        tests++; if (cpu_rdata !== 32'hFFFF_FFA5) begin fails++; $display("FAIL byte_rdata got %h exp ffffffa5", cpu_rdata); end
        tick();
        tests++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL byte_rvalid_pulse got %b exp 0", cpu_rvalid); end
        tests++; if (cpu_rdata !== 32'hFFFF_FFA5) begin fails++; $display("FAIL byte_rdata_hold got %h exp ffffffa5", cpu_rdata); end
    endtask

    task automatic test_half();
        cpu_op(1'b1, 13'h00A, 2'b01, 1'b0, 32'h0000_8001);
        tests++; if (ram_wen !== 4'b1100) begin fails++; $display("FAIL half_wen got %b exp 1100", ram_wen); end
        tests++; if (ram_wdata !== 32'h8001_8001) begin fails++; $display("FAIL half_wdata got %h exp 80018001", ram_wdata); end
        tick();
        cpu_op(1'b0, 13'h00A, 2'b01, 1'b0, 32'h0);
        tick();
        cpu_op(1'b0, 13'h00A, 2'b01, 1'b1, 32'h0);
        tests++; if (cpu_rdata !== 32'h0000_8001 || cpu_rvalid !== 1'b1) begin
            fails++; $display("FAIL half_u got %h/%b exp 00008001/1", cpu_rdata, cpu_rvalid); end
        tick();
        cpu_op(1'b0, 13'h008, 2'b10, 1'b0, 32'h0);
        tests++; if (cpu_rdata !== 32'hFFFF_8001 || cpu_rvalid !== 1'b1) begin
            fails++; $display("FAIL half_s got %h/%b exp ffff8001/1", cpu_rdata, cpu_rvalid); end
        tick();
        idle();
        tests++; if (cpu_rdata !== 32'h8001_0000 || cpu_rvalid !== 1'b1) begin
            fails++; $display("FAIL half_word got %h/%b exp 80010000/1", cpu_rdata, cpu_rvalid); end
        tick();
    endtask

    task automatic test_misalign();
        cpu_op(1'b0, 13'h00D, 2'b10, 1'b0, 32'h0);
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL mis_w_stall got %b exp 0", cpu_stall); end
        tick();
        tests++; if (cpu_misalign !== 1'b1) begin fails++; $display("FAIL mis_w_pulse got %b exp 1", cpu_misalign); end
        tests++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL mis_w_rvalid got %b exp 0", cpu_rvalid); end
        cpu_op(1'b1, 13'h003, 2'b01, 1'b0, 32'h0000_FFFF);
        tests++; if (ram_wen !== 4'b0000) begin fails++; $display("FAIL mis_h_wen got %b exp 0000", ram_wen); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL mis_h_stall got %b exp 0", cpu_stall); end
        tick();
        idle();
        tests++; if (cpu_misalign !== 1'b1) begin fails++; $display("FAIL mis_h_pulse got %b exp 1", cpu_misalign); end
        tick();
        tests++; if (cpu_misalign !== 1'b0 || cpu_rvalid !== 1'b0) begin
            fails++; $display("FAIL mis_clear got %b/%b exp 0/0", cpu_misalign, cpu_rvalid); end
        tests++; if (mem[0] !== 32'h0) begin fails++; $display("FAIL mis_h_mem got %h exp 00000000", mem[0]); end
    endtask

    task automatic test_starve();
        cpu_op(1'b0, 13'h000, 2'b10, 1'b0, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 11'd5;
        for (int i = 0; i <= 8; i++) begin
            #1;
            tests++; if (dbg_ack !== (i == 8)) begin fails++; $display("FAIL starve_ack[%0d] got %b exp %b", i, dbg_ack, (i == 8)); end
            tests++; if (cpu_stall !== (i == 8)) begin fails++; $display("FAIL starve_stall[%0d] got %b exp %b", i, cpu_stall, (i == 8)); end
            tick();
        end
        dbg_req = 1'b0;
        #1;
        tests++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
            fails++; $display("FAIL starve_rvalid got %b/%b exp 1/0", dbg_rvalid, cpu_rvalid); end
        tick();
        dbg_req = 1'b1;
        #1;
        tests++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL starve_restart got %b/%b exp 0/0", dbg_ack, cpu_stall); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_dbg();
        idle();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 11'd5; dbg_wdata = 32'h1234_5678;
        #1;
        tests++; if (dbg_ack !== 1'b1 || ram_wen !== 4'b1111 || ram_wadr !== 11'd5) begin
            fails++; $display("FAIL dbg_wr got ack %b wen %b wadr %0d exp 1/1111/5", dbg_ack, ram_wen, ram_wadr); end
        tick();
        dbg_we = 1'b0;
        #1;
        tests++; if (dbg_ack !== 1'b1 || ram_radr !== 11'd5) begin
            fails++; $display("FAIL dbg_rd got ack %b radr %0d exp 1/5", dbg_ack, ram_radr); end
        tick();
        dbg_req = 1'b0;
        #1;
        tests++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1234_5678 || cpu_rvalid !== 1'b0) begin
            fails++; $display("FAIL dbg_ret got %b/%h/%b exp 1/12345678/0", dbg_rvalid, dbg_rdata, cpu_rvalid); end
        tick();
        tests++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h1234_5678) begin
            fails++; $display("FAIL dbg_hold got %b/%h exp 0/12345678", dbg_rvalid, dbg_rdata); end
    endtask

    task automatic test_reset_midread();
        cpu_op(1'b0, 13'h008, 2'b10, 1'b0, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        tests++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL midrd_rvalid got %b exp 0", cpu_rvalid); end
        tick();
        rst_n = 1'b1;
        #1;
        tests++; if ({cpu_misalign, cpu_rvalid, dbg_rvalid} !== 3'b000) begin
            fails++; $display("FAIL midrd_regs got %b exp 000", {cpu_misalign, cpu_rvalid, dbg_rvalid}); end
        tick();
        tests++; if (cpu_rvalid !== 1'b0) begin fails++; $display("FAIL midrd_late got %b exp 0", cpu_rvalid); end
    endtask

    initial begin
        for (int i = 0; i < (1 << DRW); i++) mem[i] = 32'h0;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_size = 2'b00;
        cpu_signed = 1'b0; cpu_wdata = '0; dbg_req = 1'b0; dbg_we = 1'b0;
        dbg_adr = '0; dbg_wdata = '0;
        tick();
        test_reset();
        test_byte();
        test_half();
        test_misalign();
        test_starve();
        test_dbg();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
